// File: rtl/add4_burst_accumulator.sv
// Accumulates BURST beats of {c_out,SUM} from a 4-bit adder into a saturating total,
// counts carry-out beats, and presents each burst result on a valid/ready port.
module add4_burst_accumulator #(
    parameter int unsigned BURST = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum_in,
    input  logic             c_in,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       carry_count,
    output logic             sat_flag
);

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    localparam logic [7:0]       LastBeat = 8'(BURST - 1);
    localparam logic [ACC_W-1:0] AccMax   = {ACC_W{1'b1}};

    state_e     state;
    logic [7:0] beat_cnt;
    logic       accept;
    logic [ACC_W:0] beat_ext;
    logic [ACC_W:0] sum_ext;

    assign accept = in_valid && (state == StAcc);

    // Gate the beat so X on an ignored input never reaches the adder.
    always_comb begin
        beat_ext = '0;
        if (accept) begin
            beat_ext = {{(ACC_W - 4){1'b0}}, c_in, sum_in};
        end
        sum_ext = {1'b0, acc_out} + beat_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StAcc;
            acc_out     <= '0;
            carry_count <= '0;
            sat_flag    <= 1'b0;
            beat_cnt    <= '0;
            acc_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else if (clear) begin
            state       <= StAcc;
            acc_out     <= '0;
            carry_count <= '0;
            sat_flag    <= 1'b0;
            beat_cnt    <= '0;
            acc_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            unique case (state)
                StAcc: begin
                    if (in_valid) begin
                        acc_out     <= sum_ext[ACC_W] ? AccMax : sum_ext[ACC_W-1:0];
                        sat_flag    <= sat_flag | sum_ext[ACC_W];
                        carry_count <= carry_count + {7'b0, c_in};
                        beat_cnt    <= beat_cnt + 8'd1;
                        if (beat_cnt == LastBeat) begin
                            state     <= StOut;
                            acc_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                StOut: begin
                    if (acc_ready) begin
                        state       <= StAcc;
                        acc_out     <= '0;
                        carry_count <= '0;
                        sat_flag    <= 1'b0;
                        beat_cnt    <= '0;
                        acc_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: state <= StAcc;
            endcase
        end
    end

endmodule

// File: tb/tb_add4_burst_accumulator.sv
// Directed bench for add4_burst_accumulator: three instances cover the default,
// a long burst (BURST=16) and a narrow accumulator (ACC_W=6, BURST=3).
module tb_add4_burst_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [3:0] sum_in;
    logic       c_in;
    logic       acc_ready;

    logic       d_in_ready, d_acc_valid, d_sat;
    logic [7:0] d_acc, d_cc;
    logic       b_in_ready, b_acc_valid, b_sat;
    logic [7:0] b_acc, b_cc;
    logic       w_in_ready, w_acc_valid, w_sat;
    logic [5:0] w_acc;
    logic [7:0] w_cc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add4_burst_accumulator #(.BURST(4), .ACC_W(8)) u_def (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready),
        .sum_in(sum_in), .c_in(c_in), .acc_valid(d_acc_valid), .acc_ready(acc_ready),
        .acc_out(d_acc), .carry_count(d_cc), .sat_flag(d_sat)
    );

    add4_burst_accumulator #(.BURST(16), .ACC_W(8)) u_b16 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
        .sum_in(sum_in), .c_in(c_in), .acc_valid(b_acc_valid), .acc_ready(acc_ready),
        .acc_out(b_acc), .carry_count(b_cc), .sat_flag(b_sat)
    );

    add4_burst_accumulator #(.BURST(3), .ACC_W(6)) u_w6 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
        .sum_in(sum_in), .c_in(c_in), .acc_valid(w_acc_valid), .acc_ready(acc_ready),
        .acc_out(w_acc), .carry_count(w_cc), .sat_flag(w_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic c, input logic [3:0] s);
        in_valid = 1'b1;
        c_in     = c;
        sum_in   = s;
        tick();
        in_valid = 1'b0;
        c_in     = 1'bx;
        sum_in   = 4'bx;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        acc_ready = 1'b0;
        beat(1'b0, 4'd3);
        beat(1'b1, 4'd2);
        checks++; if (d_acc !== 8'd21) begin errors++; $display("FAIL pre_reset_acc: got %0d want 21", d_acc); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid: got %b want 0", d_acc_valid); end
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", d_in_ready); end
        checks++; if (d_acc !== 8'h00) begin errors++; $display("FAIL reset_acc_out: got %0d want 0", d_acc); end
        checks++; if (d_cc !== 8'd0) begin errors++; $display("FAIL reset_carry_count: got %0d want 0", d_cc); end
        checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", d_sat); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        acc_ready = 1'b1;
        beat(1'b0, 4'd3);
        beat(1'b1, 4'd2);
        beat(1'b0, 4'hF);
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", d_acc_valid); end
        beat(1'b1, 4'hF);
        checks++; if (d_acc_valid !== 1'b1) begin errors++; $display("FAIL basic_acc_valid: got %b want 1", d_acc_valid); end
        checks++; if (d_acc !== 8'h43) begin errors++; $display("FAIL basic_acc_out: got %0d want 67", d_acc); end
        checks++; if (d_cc !== 8'd2) begin errors++; $display("FAIL basic_carry_count: got %0d want 2", d_cc); end
        checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL basic_sat_flag: got %b want 0", d_sat); end
        checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_out: got %b want 0", d_in_ready); end
        tick();
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after: got %b want 1", d_in_ready); end
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b want 0", d_acc_valid); end
        checks++; if (d_acc !== 8'd0) begin errors++; $display("FAIL basic_acc_cleared: got %0d want 0", d_acc); end
        checks++; if (d_cc !== 8'd0) begin errors++; $display("FAIL basic_cc_cleared: got %0d want 0", d_cc); end
        acc_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        acc_ready = 1'b0;
        for (int i = 0; i < 15; i++) beat(1'b1, 4'hF);
        checks++; if (b_acc_valid !== 1'b0) begin errors++; $display("FAIL sat16_early_valid: got %b want 0", b_acc_valid); end
        beat(1'b1, 4'hF);
        checks++; if (b_acc_valid !== 1'b1) begin errors++; $display("FAIL sat16_acc_valid: got %b want 1", b_acc_valid); end
        checks++; if (b_acc !== 8'hFF) begin errors++; $display("FAIL sat16_acc_out: got %0d want 255", b_acc); end
        checks++; if (b_sat !== 1'b1) begin errors++; $display("FAIL sat16_sat_flag: got %b want 1", b_sat); end
        checks++; if (b_cc !== 8'd16) begin errors++; $display("FAIL sat16_carry_count: got %0d want 16", b_cc); end
        // The ACC_W=6 instance saw its 3-beat burst first and has been stalled since.
        checks++; if (w_acc_valid !== 1'b1) begin errors++; $display("FAIL w6_acc_valid: got %b want 1", w_acc_valid); end
        checks++; if (w_acc !== 6'h3F) begin errors++; $display("FAIL w6_acc_out: got %0d want 63", w_acc); end
        checks++; if (w_sat !== 1'b1) begin errors++; $display("FAIL w6_sat_flag: got %b want 1", w_sat); end
        checks++; if (w_cc !== 8'd3) begin errors++; $display("FAIL w6_carry_count: got %0d want 3", w_cc); end
        checks++; if (d_sat !== 1'b0) begin errors++; $display("FAIL def_no_sat_124: got %b want 0", d_sat); end
        checks++; if (d_acc !== 8'd124) begin errors++; $display("FAIL def_acc_124: got %0d want 124", d_acc); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        acc_ready = 1'b0;
        beat(1'b0, 4'd1);
        beat(1'b0, 4'd2);
        beat(1'b0, 4'd3);
        beat(1'b0, 4'd4);
        in_valid = 1'b1;
        c_in     = 1'b1;
        sum_in   = 4'd9;
        for (int i = 0; i < 5; i++) begin
            checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, d_in_ready); end
            checks++; if (d_acc !== 8'd10) begin errors++; $display("FAIL bp_acc_hold[%0d]: got %0d want 10", i, d_acc); end
            checks++; if (d_acc_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, d_acc_valid); end
            tick();
        end
        checks++; if (d_cc !== 8'd0) begin errors++; $display("FAIL bp_cc_hold: got %0d want 0", d_cc); end
        in_valid  = 1'b0;
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_fall: got %b want 0", d_acc_valid); end
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b want 1", d_in_ready); end
        for (int i = 0; i < 4; i++) beat(1'b1, 4'd1);
        checks++; if (d_acc !== 8'd68) begin errors++; $display("FAIL bp_next_acc: got %0d want 68", d_acc); end
        checks++; if (d_cc !== 8'd4) begin errors++; $display("FAIL bp_next_cc: got %0d want 4", d_cc); end
        checks++; if (d_acc_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", d_acc_valid); end
    endtask

    task automatic test_clear();
        do_reset();
        acc_ready = 1'b0;
        beat(1'b0, 4'd2);
        beat(1'b0, 4'd3);
        checks++; if (d_acc !== 8'd5) begin errors++; $display("FAIL clr_pre_acc: got %0d want 5", d_acc); end
        clear    = 1'b1;
        in_valid = 1'b1;
        c_in     = 1'b1;
        sum_in   = 4'd7;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if (d_acc !== 8'd0) begin errors++; $display("FAIL clr_acc: got %0d want 0", d_acc); end
        checks++; if (d_cc !== 8'd0) begin errors++; $display("FAIL clr_cc: got %0d want 0", d_cc); end
        beat(1'b0, 4'd1);
        beat(1'b0, 4'd1);
        beat(1'b0, 4'd1);
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL clr_counter_reset: got %b want 0", d_acc_valid); end
        beat(1'b1, 4'd0);
        checks++; if (d_acc_valid !== 1'b1) begin errors++; $display("FAIL clr_fresh_valid: got %b want 1", d_acc_valid); end
        checks++; if (d_acc !== 8'd19) begin errors++; $display("FAIL clr_fresh_acc: got %0d want 19", d_acc); end
        checks++; if (d_cc !== 8'd1) begin errors++; $display("FAIL clr_fresh_cc: got %0d want 1", d_cc); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %b want 0", d_acc_valid); end
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL clr_out_in_ready: got %b want 1", d_in_ready); end
        checks++; if (d_acc !== 8'd0) begin errors++; $display("FAIL clr_out_acc: got %0d want 0", d_acc); end
    endtask

    task automatic test_reset_mid_out();
        do_reset();
        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(1'b1, 4'hF);
        checks++; if (d_acc_valid !== 1'b1) begin errors++; $display("FAIL rmo_pre_valid: got %b want 1", d_acc_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (d_acc_valid !== 1'b0) begin errors++; $display("FAIL rmo_valid: got %b want 0", d_acc_valid); end
        checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL rmo_in_ready: got %b want 1", d_in_ready); end
        checks++; if (d_acc !== 8'd0) begin errors++; $display("FAIL rmo_acc: got %0d want 0", d_acc); end
        checks++; if (d_cc !== 8'd0) begin errors++; $display("FAIL rmo_cc: got %0d want 0", d_cc); end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) beat(1'b0, 4'd1);
        checks++; if (d_acc_valid !== 1'b1) begin errors++; $display("FAIL rmo_next_valid: got %b want 1", d_acc_valid); end
        checks++; if (d_acc !== 8'd4) begin errors++; $display("FAIL rmo_next_acc: got %0d want 4", d_acc); end
        checks++; if (d_cc !== 8'd0) begin errors++; $display("FAIL rmo_next_cc: got %0d want 0", d_cc); end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        c_in      = 1'b0;
        sum_in    = 4'd0;
        acc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_back_pressure();
        test_clear();
        test_reset_mid_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
